// File: rtl/byte_pair_pkg.sv
// Shared types and constants for the byte-pair loader.
// Holds the loader FSM state encoding and the pair-ordering helper.
package byte_pair_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } pair_state_e;

  // Returns {high, low} for a pair received as first then second.
  function automatic logic [2*BYTE_W-1:0] order_pair(input logic              high_first,
                                                     input logic [BYTE_W-1:0] first_byte,
                                                     input logic [BYTE_W-1:0] second_byte);
    return high_first ? {first_byte, second_byte} : {second_byte, first_byte};
  endfunction

endpackage

// File: rtl/pair_timeout_timer.sv
// Idle-cycle counter for a half-assembled pair.
// Expires on the enabled edge that brings the count to TERMINAL; TERMINAL = 0 never expires.
module pair_timeout_timer #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TERMINAL == 0) ? 32'd0 : TERMINAL - 1);
  localparam bit ACTIVE = (TERMINAL != 0);

  logic [CNT_W-1:0] r_count;
  logic             w_hit;

  assign w_hit     = ACTIVE && (r_count == LAST);
  assign o_expired = i_enable && w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/byte_pair_loader.sv
// Assembles two serial bytes into a registered high/low pair with a ready/valid handshake
// on both sides, an idle timeout on half pairs, and a consumed-pair counter.
module byte_pair_loader
  import byte_pair_pkg::*;
#(
  parameter bit          HIGH_FIRST     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [BYTE_W-1:0] i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  input  logic              i_flush,
  output logic [BYTE_W-1:0] o_high_byte,
  output logic [BYTE_W-1:0] o_low_byte,
  output logic              o_pair_valid,
  input  logic              i_pair_ready,
  output logic              o_timeout_err,
  output logic [7:0]        o_pair_count
);

  pair_state_e       r_state, w_state_d;
  logic [BYTE_W-1:0] r_first, w_first_d;
  logic [BYTE_W-1:0] r_high, w_high_d;
  logic [BYTE_W-1:0] r_low, w_low_d;
  logic              r_timeout_err, w_timeout_err_d;
  logic [7:0]        r_pair_count, w_pair_count_d;

  logic              w_accept;
  logic              w_consume;
  logic              w_timer_clear;
  logic              w_timer_enable;
  logic              w_expired;
  logic [2*BYTE_W-1:0] w_pair;

  // Full only frees its slot in the same cycle the pair leaves.
  assign o_byte_ready = i_rst_n && !i_flush && ((r_state != StFull) || i_pair_ready);
  assign o_pair_valid = (r_state == StFull);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_consume    = o_pair_valid && i_pair_ready && !i_flush;
  assign w_pair       = order_pair(HIGH_FIRST, r_first, i_byte_in);

  pair_timeout_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d       = r_state;
    w_first_d       = r_first;
    w_high_d        = r_high;
    w_low_d         = r_low;
    w_timeout_err_d = 1'b0;
    w_pair_count_d  = r_pair_count;
    w_timer_clear   = 1'b0;
    w_timer_enable  = 1'b0;

    if (i_flush) begin
      w_state_d     = StEmpty;
      w_first_d     = '0;
      w_high_d      = '0;
      w_low_d       = '0;
      w_timer_clear = 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          w_timer_clear = 1'b1;
          if (w_accept) begin
            w_first_d = i_byte_in;
            w_state_d = StHalf;
          end
        end
        StHalf: begin
          if (w_accept) begin
            // Accept wins over a timeout landing on the same edge.
            {w_high_d, w_low_d} = w_pair;
            w_timer_clear       = 1'b1;
            w_state_d           = StFull;
          end else begin
            w_timer_enable = 1'b1;
            if (w_expired) begin
              w_first_d       = '0;
              w_timeout_err_d = 1'b1;
              w_state_d       = StEmpty;
            end
          end
        end
        StFull: begin
          w_timer_clear = 1'b1;
          if (w_consume) begin
            w_pair_count_d = r_pair_count + 8'd1;
            if (w_accept) begin
              w_first_d = i_byte_in;
              w_state_d = StHalf;
            end else begin
              w_state_d = StEmpty;
            end
          end
        end
        default: begin
          w_state_d     = StEmpty;
          w_timer_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StEmpty;
      r_first       <= '0;
      r_high        <= '0;
      r_low         <= '0;
      r_timeout_err <= 1'b0;
      r_pair_count  <= '0;
    end else begin
      r_state       <= w_state_d;
      r_first       <= w_first_d;
      r_high        <= w_high_d;
      r_low         <= w_low_d;
      r_timeout_err <= w_timeout_err_d;
      r_pair_count  <= w_pair_count_d;
    end
  end

  assign o_high_byte   = r_high;
  assign o_low_byte    = r_low;
  assign o_timeout_err = r_timeout_err;
  assign o_pair_count  = r_pair_count;

endmodule

// File: tb/tb_byte_pair_loader.sv
// Bench for byte_pair_loader: two instances (high-first and low-first, timeout 4) share stimulus
// and are checked against a queue-based model of the pairing rules.
module tb_byte_pair_loader;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       byte_valid = 1'b0;
  logic       pair_ready = 1'b0;
  logic [7:0] byte_in = 8'h00;

  logic       rdy[2], pv[2], terr[2];
  logic [7:0] hi[2], lo[2], cnt[2];

  int n_tests = 0;
  int n_fail = 0;

  // Model: pending first byte in a queue, completed pair as (first, second) arrival order.
  logic [7:0] m_pend[$];
  bit         m_full;
  logic [7:0] m_b1, m_b2;
  int         m_wait;
  bit         m_terr;
  int         m_count;

  always #5 clk = ~clk;

  byte_pair_loader #(.HIGH_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) dut_h (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(byte_valid),
    .o_byte_ready(rdy[0]), .i_flush(flush), .o_high_byte(hi[0]), .o_low_byte(lo[0]),
    .o_pair_valid(pv[0]), .i_pair_ready(pair_ready), .o_timeout_err(terr[0]),
    .o_pair_count(cnt[0])
  );

  byte_pair_loader #(.HIGH_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) dut_l (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(byte_valid),
    .o_byte_ready(rdy[1]), .i_flush(flush), .o_high_byte(hi[1]), .o_low_byte(lo[1]),
    .o_pair_valid(pv[1]), .i_pair_ready(pair_ready), .o_timeout_err(terr[1]),
    .o_pair_count(cnt[1])
  );

  function automatic logic exp_ready();
    return rst_n && !flush && (!m_full || pair_ready);
  endfunction

  function automatic logic [7:0] exp_hi(input int d);
    return (d == 0) ? m_b1 : m_b2;
  endfunction

  function automatic logic [7:0] exp_lo(input int d);
    return (d == 0) ? m_b2 : m_b1;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_full = 0; m_b1 = 8'h00; m_b2 = 8'h00; m_wait = 0; m_terr = 0; m_count = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = byte_valid && exp_ready();
    m_terr = 0;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_pend.delete();
      m_full = 0; m_b1 = 8'h00; m_b2 = 8'h00; m_wait = 0;
    end else if (m_full) begin
      if (pair_ready) begin
        m_count++;
        m_full = 0;
      end
      if (acc) begin
        m_pend.push_back(byte_in);
        m_wait = 0;
      end
    end else if (m_pend.size() != 0) begin
      if (acc) begin
        m_b1 = m_pend.pop_front();
        m_b2 = byte_in;
        m_full = 1;
      end else begin
        m_wait++;
        if (TO != 0 && m_wait == TO) begin
          m_pend.delete();
          m_terr = 1;
        end
      end
    end else if (acc) begin
      m_pend.push_back(byte_in);
      m_wait = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic pr, input logic fl);
    byte_valid = v; byte_in = b; pair_ready = pr; flush = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    model_reset();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (rdy[d] !== 1'b0 || pv[d] !== 1'b0 || terr[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d got rdy=%b pv=%b terr=%b want 0 0 0", d, rdy[d], pv[d],
                 terr[d]);
      end
      n_tests++;
      if (hi[d] !== 8'h00 || lo[d] !== 8'h00 || cnt[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_data dut%0d got hi=%h lo=%h cnt=%h want 00 00 00", d, hi[d], lo[d],
                 cnt[d]);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pair_order(input logic [7:0] b1, input logic [7:0] b2);
    int c0;
    c0 = m_count;
    drive(1'b1, b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, b2, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++;
    if (pv[0] !== 1'b1 || hi[0] !== b1 || lo[0] !== b2) begin
      n_fail++;
      $display("FAIL order_hf1 got pv=%b hi=%h lo=%h want 1 %h %h", pv[0], hi[0], lo[0], b1, b2);
    end
    n_tests++;
    if (pv[1] !== 1'b1 || hi[1] !== b2 || lo[1] !== b1) begin
      n_fail++;
      $display("FAIL order_hf0 got pv=%b hi=%h lo=%h want 1 %h %h", pv[1], hi[1], lo[1], b2, b1);
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (pv[d] !== 1'b0 || cnt[d] !== 8'(c0 + 1) || hi[d] !== exp_hi(d)) begin
        n_fail++;
        $display("FAIL consume dut%0d got pv=%b cnt=%h hi=%h want 0 %h %h", d, pv[d], cnt[d],
                 hi[d], 8'(c0 + 1), exp_hi(d));
      end
    end
  endtask

  task automatic test_backpressure();
    int c0;
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h43, 1'b0, 1'b0);
    tick();
    c0 = m_count;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (rdy[0] !== 1'b0 || rdy[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready cyc %0d got %b %b want 0 0", i, rdy[0], rdy[1]);
      end
      tick();
      n_tests++;
      if (pv[0] !== 1'b1 || hi[0] !== 8'h21 || lo[0] !== 8'h43 || cnt[0] !== 8'(c0)) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got pv=%b hi=%h lo=%h cnt=%h want 1 21 43 %h", i, pv[0],
                 hi[0], lo[0], cnt[0], 8'(c0));
      end
    end
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready got %b want 1", rdy[0]);
    end
    tick();
    n_tests++;
    if (pv[0] !== 1'b0 || cnt[0] !== 8'(c0 + 1)) begin
      n_fail++;
      $display("FAIL bp_consume got pv=%b cnt=%h want 0 %h", pv[0], cnt[0], 8'(c0 + 1));
    end
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (pv[0] !== 1'b1 || hi[0] !== 8'h77 || lo[0] !== 8'h88) begin
      n_fail++;
      $display("FAIL bp_next_pair got pv=%b hi=%h lo=%h want 1 77 88", pv[0], hi[0], lo[0]);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      n_tests++;
      if (terr[0] !== ((i == TO) ? 1'b1 : 1'b0) || terr[1] !== terr[0] || pv[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_pulse edge %0d got terr=%b/%b pv=%b want %b", i, terr[0], terr[1],
                 pv[0], (i == TO));
      end
    end
    // After abort the next byte must start a fresh pair.
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < TO; i++) tick();
    drive(1'b1, 8'hE3, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (terr[0] !== 1'b0 || pv[0] !== 1'b1 || hi[0] !== 8'hD2 || lo[0] !== 8'hE3) begin
      n_fail++;
      $display("FAIL timeout_race got terr=%b pv=%b hi=%h lo=%h want 0 1 d2 e3", terr[0], pv[0],
               hi[0], lo[0]);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    int c0;
    c0 = m_count;
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready got %b want 0", rdy[0]);
    end
    tick();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (hi[0] !== 8'h11 || lo[0] !== 8'h22 || pv[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_half got hi=%h lo=%h pv=%b want 11 22 1", hi[0], lo[0], pv[0]);
    end
    drive(1'b1, 8'h33, 1'b1, 1'b1);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (pv[d] !== 1'b0 || hi[d] !== 8'h00 || lo[d] !== 8'h00 || cnt[d] !== 8'(c0)) begin
        n_fail++;
        $display("FAIL flush_full dut%0d got pv=%b hi=%h lo=%h cnt=%h want 0 00 00 %h", d, pv[d],
                 hi[d], lo[d], cnt[d], 8'(c0));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h20, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (rdy[0] !== 1'b0 || pv[0] !== 1'b0 || cnt[0] !== 8'h00 || hi[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async got rdy=%b pv=%b cnt=%h hi=%h want 0 0 00 00", rdy[0], pv[0],
               cnt[0], hi[0]);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    n_tests++;
    if (pv[0] !== 1'b1 || hi[0] !== 8'h44 || lo[0] !== 8'h66) begin
      n_fail++;
      $display("FAIL reset_restart got pv=%b hi=%h lo=%h want 1 44 66", pv[0], hi[0], lo[0]);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_wrap();
    int cyc;
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    while (m_count < 257 && cyc < 2000) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      tick();
      cyc++;
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++;
    if (m_count != 257 || cnt[0] !== 8'h01 || cnt[1] !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap got cnt=%h/%h after %0d pairs want 01", cnt[0], cnt[1], m_count);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3));
      if (i % 8 == 0) drive(1'b0, 8'h00, 1'b0, 1'b0);  // idle runs to exercise the timeout
      #1;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (rdy[d] !== exp_ready()) begin
          n_fail++;
          $display("FAIL rand_ready dut%0d cyc %0d got %b want %b", d, i, rdy[d], exp_ready());
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (pv[d] !== m_full || hi[d] !== exp_hi(d) || lo[d] !== exp_lo(d) ||
            terr[d] !== m_terr || cnt[d] !== 8'(m_count)) begin
          n_fail++;
          $display("FAIL rand_out dut%0d cyc %0d got pv=%b hi=%h lo=%h terr=%b cnt=%h want %b %h %h %b %h",
                   d, i, pv[d], hi[d], lo[d], terr[d], cnt[d], m_full, exp_hi(d), exp_lo(d),
                   m_terr, 8'(m_count));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pair_order(8'hA5, 8'h3C);
    test_pair_order(8'h12, 8'h34);
    test_backpressure();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_pair_loader.md
BYTE_PAIR_LOADER -- requirements
Module: byte_pair_loader

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 1; 1 = first byte of a pair is HIGH_BYTE, 0 = first byte is LOW_BYTE.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255; cycles allowed in HALF before the partial pair is aborted; 0 disables the timeout.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 BYTE_IN  in  8  incoming serial byte.
REQ-007 BYTE_VALID  in  1  BYTE_IN valid.
REQ-008 BYTE_READY  out  1  loader accepts BYTE_IN this cycle.
REQ-009 FLUSH  in  1  synchronous clear of the partial or held pair.
REQ-010 HIGH_BYTE  out  8  registered high byte of the assembled pair.
REQ-011 LOW_BYTE  out  8  registered low byte of the assembled pair.
REQ-012 PAIR_VALID  out  1  HIGH_BYTE/LOW_BYTE hold a complete pair.
REQ-013 PAIR_READY  in  1  downstream consumes the pair.
REQ-014 TIMEOUT_ERR  out  1  one-cycle pulse on a partial-pair abort.
REQ-015 PAIR_COUNT  out  8  count of consumed pairs, wraps 255->0.

Function
REQ-016 A byte is accepted on a rising edge with BYTE_VALID=1 and BYTE_READY=1; a pair is consumed on a rising edge with PAIR_VALID=1 and PAIR_READY=1.
REQ-017 The FSM SHALL have states EMPTY, HALF and FULL; PAIR_VALID SHALL be 1 exactly in FULL.
REQ-018 BYTE_READY SHALL be: 1 in EMPTY and HALF; equal to PAIR_READY in FULL; 0 whenever FLUSH=1 or RST_N=0.
REQ-019 EMPTY + accept -> store the byte in an internal first-byte register, clear the timer, go to HALF.
REQ-020 HALF + accept -> load HIGH_BYTE/LOW_BYTE from the first-byte register and BYTE_IN (order per HIGH_FIRST), go to FULL; PAIR_VALID=1 on the following cycle (1-cycle latency from the second byte).
REQ-021 HALF without accept -> timer increments; when it reaches TIMEOUT_CYCLES -> discard the first byte, go to EMPTY, TIMEOUT_ERR=1 for exactly one cycle.
REQ-022 Accept and timeout on the same edge -> accept wins; no TIMEOUT_ERR.
REQ-023 FULL + consume + accept -> new first byte stored, go to HALF; FULL + consume only -> EMPTY; FULL without consume -> hold, outputs stable.
REQ-024 HIGH_BYTE/LOW_BYTE SHALL change only on pair completion (REQ-020) or FLUSH; after consume they hold the last pair.
REQ-025 PAIR_COUNT SHALL increment by 1 (modulo 256) on every consume.
REQ-026 FLUSH=1 SHALL have highest priority: next state EMPTY, timer cleared, HIGH_BYTE/LOW_BYTE/first-byte register cleared to 0x00, no TIMEOUT_ERR, no consume counted, PAIR_COUNT unchanged.

Reset
REQ-027 While RST_N=0: state EMPTY, HIGH_BYTE=LOW_BYTE=0x00, first-byte register 0x00, PAIR_VALID=0, TIMEOUT_ERR=0, PAIR_COUNT=0x00, timer 0, BYTE_READY=0.
REQ-028 Reset asserted mid-pair or in FULL SHALL discard all data immediately; the first accept after release starts a new pair.

Structure
REQ-029 Package byte_pair_pkg SHALL hold the FSM state enum and the constant BYTE_W=8.
REQ-030 The timeout counter SHALL be a sub-module pair_timeout_timer (clear, enable, parameterised terminal count, expired flag).

Verification
REQ-031 HIGH_FIRST=1: bytes 0xA5, 0x3C back-to-back, PAIR_READY=1 -> HIGH_BYTE=0xA5, LOW_BYTE=0x3C, PAIR_VALID high 1 cycle, PAIR_COUNT=1.
REQ-032 HIGH_FIRST=0: bytes 0x12, 0x34 -> HIGH_BYTE=0x34, LOW_BYTE=0x12.
REQ-033 PAIR_READY=0 for 5 cycles in FULL with BYTE_VALID=1 -> BYTE_READY=0, outputs stable; then PAIR_READY=1 with byte 0x77 -> same-edge consume, state HALF, PAIR_COUNT increments.
REQ-034 TIMEOUT_CYCLES=4: one byte, then idle -> TIMEOUT_ERR pulses 4 cycles after entering HALF, state EMPTY; second byte exactly on the timeout edge -> pair completes, no TIMEOUT_ERR.
REQ-035 257 consecutive pairs -> PAIR_COUNT wraps to 0x01.
REQ-036 FLUSH in HALF and in FULL, and RST_N low mid-pair -> EMPTY, outputs 0x00, PAIR_VALID=0, PAIR_COUNT unchanged on FLUSH and 0 on reset.
